// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types, bit positions, FSM encoding and the encode function
// used by the serializer, the checker and verification.
package hamming_pkg;

  typedef logic [3:0] data_t;
  typedef logic [6:0] code_t;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int D0_POS = 2;
  localparam int P2_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Parity equations match the checker: each parity covers the data bits whose
  // 1-based position has the corresponding bit set.
  function automatic code_t hamming_encode(input data_t d);
    code_t cw;
    cw[D0_POS] = d[0];
    cw[D1_POS] = d[1];
    cw[D2_POS] = d[2];
    cw[D3_POS] = d[3];
    cw[P0_POS] = d[3] ^ d[1] ^ d[0];
    cw[P1_POS] = d[3] ^ d[2] ^ d[0];
    cw[P2_POS] = d[3] ^ d[2] ^ d[1];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_encoder.sv
// Hamming(7,4) encoder: nibble -> 7-bit codeword.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic [3:0] data,
  output logic [6:0] code
);

  assign code = hamming_encode(data);

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) encode + framed serial TX (start, 7 code bits LSB first, stop); HAMMING_ERR_INJECT_EN adds inj_mask.
// Latency: tx falls the cycle after the transfer edge; frame is 9*BIT_CYCLES cycles, done on the last stop cycle.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, nothing is buffered.
module hamming_tx_serializer
  import hamming_pkg::*;
#(
  parameter int BIT_CYCLES = 4
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [6:0] codeword
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic [6:0] inj_mask
`endif
);

  localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] LAST_BIT = 3'(D3_POS);

  tx_state_t  state;
  tx_state_t  state_nxt;
  logic [7:0] cyc_cnt;
  logic [2:0] bit_idx;
  logic       bit_end;
  logic       xfer;
  code_t      enc_word;
  code_t      load_word;

  hamming_encoder u_encoder (
    .data (in_data),
    .code (enc_word)
  );

`ifdef HAMMING_ERR_INJECT_EN
  assign load_word = enc_word ^ inj_mask;
`else
  assign load_word = enc_word;
`endif

  assign bit_end = (cyc_cnt == LAST_CYC);
  assign xfer    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer)                            state_nxt = START;
      START:   if (bit_end)                         state_nxt = DATA;
      DATA:    if (bit_end && (bit_idx == LAST_BIT)) state_nxt = STOP;
      STOP:    if (bit_end)                         state_nxt = IDLE;
      default:                                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx       = 1'b1;
    busy     = (state != IDLE);
    in_ready = (state == IDLE);
    done     = 1'b0;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = codeword[bit_idx];
      STOP:    done = bit_end;
      default: tx = 1'b1;
    endcase
  end

  // Counters rest at zero in IDLE so every frame starts from a clean bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= 8'd0;
      bit_idx <= 3'd0;
    end else if (state == IDLE) begin
      cyc_cnt <= 8'd0;
      bit_idx <= 3'd0;
    end else begin
      cyc_cnt <= bit_end ? 8'd0 : cyc_cnt + 8'd1;
      if ((state == DATA) && bit_end) begin
        bit_idx <= (bit_idx == LAST_BIT) ? 3'd0 : bit_idx + 3'd1;
      end
    end
  end

  // The shifted word is this register, so in_data may change freely mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      codeword <= 7'd0;
    end else if (xfer) begin
      codeword <= load_word;
    end
  end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Scoreboard bench for hamming_tx_serializer: stimulus pushes expected codewords,
// a monitor deserializes tx frames and compares them.
`timescale 1ns/1ps
module tb_hamming_tx_serializer;

  localparam int BC = 4;

  typedef struct packed {
    logic [6:0] code;
    logic [2:0] syn;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       done;
  logic [6:0] codeword;
`ifdef HAMMING_ERR_INJECT_EN
  logic [6:0] inj_mask = 7'd0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  sb_item_t   sb_q[$];
  logic [6:0] exp_tab [16];
  bit         in_frame = 1'b0;

  hamming_tx_serializer #(.BIT_CYCLES(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .codeword (codeword)
`ifdef HAMMING_ERR_INJECT_EN
    ,
    .inj_mask (inj_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[6] ^ c[5] ^ c[4] ^ c[3], c[6] ^ c[5] ^ c[2] ^ c[1], c[6] ^ c[4] ^ c[2] ^ c[0]};
  endfunction

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [3:0] d, input logic hold, input logic expect_frame,
                      input logic [6:0] exp_code, input logic [2:0] exp_syn);
    int waited;
    sb_item_t item;
    waited   = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    if (in_ready) begin
      @(posedge clk);
      if (expect_frame) begin
        item.code = exp_code;
        item.syn  = exp_syn;
        sb_q.push_back(item);
      end
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge; bit k is taken mid-period.
  initial begin
    int         fc;
    logic [6:0] rx;
    bit         bad;
    bit         prev_done;
    sb_item_t   item;
    fc = 0; rx = 7'd0; bad = 1'b0; prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_frame  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (!in_frame) begin
          check("idle_done", 32'(done), 32'd0);
          if (prev_done) check("ready_after_done", 32'(in_ready), 32'd1);
          if (tx == 1'b0) begin
            in_frame = 1'b1;
            fc  = 0;
            rx  = 7'd0;
            bad = 1'b0;
          end
        end
        if (in_frame) begin
          if (!busy || in_ready) bad = 1'b1;
          if (fc % BC == BC / 2) begin
            if (fc / BC == 0 && tx !== 1'b0) bad = 1'b1;
            else if (fc / BC == 8 && tx !== 1'b1) bad = 1'b1;
            else if (fc / BC >= 1 && fc / BC <= 7) rx[fc / BC - 1] = tx;
          end
          if (fc == 9 * BC - 1) begin
            check("done_at_frame_end", 32'(done), 32'd1);
            check("frame_shape", 32'(bad), 32'd0);
            if (sb_q.size() == 0) begin
              check("frame_expected", 32'd0, 32'd1);
            end else begin
              item = sb_q.pop_front();
              check("tx_word", 32'(rx), 32'(item.code));
              check("codeword_port", 32'(codeword), 32'(item.code));
              check("syndrome", 32'(syndrome(rx)), 32'(item.syn));
            end
            in_frame = 1'b0;
          end else if (done) begin
            bad = 1'b1;
          end
          fc++;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    int waited;
    exp_tab[0]  = 7'b0000000; exp_tab[1]  = 7'b0000111;
    exp_tab[2]  = 7'b0011001; exp_tab[3]  = 7'b0011110;
    exp_tab[4]  = 7'b0101010; exp_tab[5]  = 7'b0101101;
    exp_tab[6]  = 7'b0110011; exp_tab[7]  = 7'b0110100;
    exp_tab[8]  = 7'b1001011; exp_tab[9]  = 7'b1001100;
    exp_tab[10] = 7'b1010010; exp_tab[11] = 7'b1010101;
    exp_tab[12] = 7'b1100001; exp_tab[13] = 7'b1100110;
    exp_tab[14] = 7'b1111000; exp_tab[15] = 7'b1111111;

    // Reset state, then ten idle cycles.
    repeat (3) @(negedge clk);
    check("rst_tx",       32'(tx),       32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_codeword", 32'(codeword), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_lines", {29'd0, tx, busy, in_ready}, 32'b101);
    end

    // Single frame of 1011.
    send(4'b1011, 1'b0, 1'b1, 7'b1010101, 3'b000);
    check("cw_1011", 32'(codeword), 32'(7'b1010101));

    // All sixteen nibbles back to back with in_valid held.
    for (int d = 0; d < 16; d++) send(4'(d), 1'b1, 1'b1, exp_tab[d], 3'b000);
    in_valid = 1'b0;

    // in_valid pulse mid-frame is ignored.
    send(4'b1100, 1'b0, 1'b1, exp_tab[12], 3'b000);
    repeat (9) @(negedge clk);
    in_data  = 4'b0101;
    in_valid = 1'b1;
    check("midframe_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("midframe_codeword", 32'(codeword), 32'(7'b1100001));

    // Reset during DATA bit 3 abandons the frame.
    send(4'b0110, 1'b0, 1'b0, 7'd0, 3'd0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx",       32'(tx),       32'd1);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_codeword", 32'(codeword), 32'd0);
    check("abort_done",     32'(done),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(4'b1001, 1'b0, 1'b1, 7'b1001100, 3'b000);

`ifdef HAMMING_ERR_INJECT_EN
    inj_mask = 7'b0000100;
    send(4'b1011, 1'b0, 1'b1, 7'b1010001, 3'b011);
    inj_mask = 7'b0000000;
`endif

    waited = 0;
    while ((sb_q.size() != 0 || in_frame) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
